seg7_scan_decoder: RTL

//  Inverse of the hex-to-7-segment encoder. Samples a multiplexed 7-segment bus
//  (active-low segments plus one-hot digit select) and decodes each digit back to
//  a 4-bit hex nibble. Each digit is stored in a per-digit register. Sits on the

---
 rtl/seg7_scan_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_decoder
// Brief  : Watches a multiplexed active-low 7-segment bus with one-hot digit
//          select and decodes each displayed digit back to a hex nibble.
//          A bus word is accepted once it has been stable long enough, and is
//          written once per stable period into a per-digit register.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic                    update_o,
    output logic                    err_o,
    output logic                    err_seen_o
);

    localparam int                    WORD_W     = NUM_DIGITS + 7;
    // cnt counts prior equal samples; the current equal sample makes the total
    localparam logic [7:0]            ACCEPT_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    logic [WORD_W-1:0]       meta_q;
    logic [WORD_W-1:0]       sync_q;   // synced word s
    logic [WORD_W-1:0]       prev_q;   // previous synced word p
    logic [7:0]              cnt_q;
    logic [7:0]              cnt_d;
    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;

    logic [NUM_DIGITS-1:0]   s_sel;
    logic [6:0]              s_seg;
    logic                    s_stable;
    logic                    sel_multi;
    logic                    seg_blank;
    logic                    dec_hit;
    logic [3:0]              dec_nib;
    logic                    cap_err;

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    update_q;
    logic                    err_q;
    logic                    err_seen_q;

    assign s_sel     = sync_q[WORD_W-1:7];
    assign s_seg     = sync_q[6:0];
    assign s_stable  = (sync_q == prev_q);
    assign sel_multi = ((s_sel & (s_sel - SEL_ONE)) != '0);
    assign seg_blank = (s_seg == 7'h7F);
    assign cap_err   = sel_multi || (!dec_hit && !seg_blank);

    // Two-flop synchroniser on the whole bus word plus one-word history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= {dig_sel_i, seg_n_i};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Stability counter: restarts on any change, saturates at its maximum
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !s_stable) begin
            cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter and state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next-state logic; accept marks the cycle in which a capture is taken
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_sel != '0) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (s_sel == '0) begin
                    state_d = ST_IDLE;
                end else if (s_stable && (cnt_q >= ACCEPT_CNT)) begin
                    accept  = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (s_sel == '0) begin
                    state_d = ST_IDLE;
                end else if (!s_stable) begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
        end
    end

    // Segment pattern to nibble lookup on the synced segment field
    always_comb begin
        dec_hit = 1'b1;
        dec_nib = 4'h0;
        case (s_seg)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h18: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    // Capture registers; clear wins over a capture in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
        end else if (clear_i) begin
            value_q    <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            update_q <= accept && !sel_multi;
            err_q    <= accept && cap_err;
            if (accept && cap_err) err_seen_q <= 1'b1;
            // Multi-hot select never writes; a one-hot select writes one digit
            if (accept && !sel_multi) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (s_sel[k]) begin
                        if (dec_hit) begin
                            value_q[4*k +: 4] <= dec_nib;
                        end else if (seg_blank) begin
                            value_q[4*k +: 4] <= 4'h0;
                        end
                        valid_q[k] <= dec_hit;
                    end
                end
            end
        end
    end

    assign value_o       = value_q;
    assign digit_valid_o = valid_q;
    assign update_o      = update_q;
    assign err_o         = err_q;
    assign err_seen_o    = err_seen_q;

endmodule
`default_nettype wire
